// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write port of the boot loader.
// The loader connects through the slave modport; the byte source and memory connect through master.
interface imem_loader_if #(
  parameter int IMEM_AW = 10
);
  logic               byte_valid_i;
  logic [7:0]         byte_data_i;
  logic               byte_ready_o;
  logic               imem_wen_o;
  logic [IMEM_AW-1:0] imem_addr_o;
  logic [31:0]        imem_wdata_o;

  modport master (
    output byte_valid_i,
    output byte_data_i,
    input  byte_ready_o,
    input  imem_wen_o,
    input  imem_addr_o,
    input  imem_wdata_o
  );

  modport slave (
    input  byte_valid_i,
    input  byte_data_i,
    output byte_ready_o,
    output imem_wen_o,
    output imem_addr_o,
    output imem_wdata_o
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time loader: assembles a framed little-endian byte stream into instruction
// words, writes them from address 0 upward, and releases the core only after the checksum verifies.
module imem_loader #(
  parameter int IMEM_AW = 10
) (
  input  logic             clk,
  input  logic             reset,
  imem_loader_if.slave     bus,
  input  logic             restart_i,
  output logic             core_rst_o,
  output logic             load_done_o,
  output logic             load_err_o
);

  typedef enum logic [2:0] {LEN0, LEN1, DATA, CSUM, DONE, ERR} state_t;

  localparam logic [16:0] CAPACITY = 17'(1) << IMEM_AW;

  state_t             state_q, state_d;
  logic [7:0]         lenLo_q, lenLo_d;
  logic [IMEM_AW-1:0] lastIdx_q, lastIdx_d;
  logic [IMEM_AW-1:0] wordCnt_q, wordCnt_d;
  logic [1:0]         byteCnt_q, byteCnt_d;
  logic [7:0]         acc_q, acc_d;
  logic [23:0]        wordBuf_q, wordBuf_d;
  logic               wen_q, wen_d;
  logic [IMEM_AW-1:0] addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               coreRst_q, coreRst_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic        active;
  logic        ready;
  logic        accept;
  logic [15:0] lenWord;

  assign active  = (state_q == LEN0) || (state_q == LEN1) || (state_q == DATA) || (state_q == CSUM);
  assign ready   = active && !restart_i;
  assign accept  = ready && bus.byte_valid_i;
  assign lenWord = {bus.byte_data_i, lenLo_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= LEN0;
      lenLo_q   <= '0;
      lastIdx_q <= '0;
      wordCnt_q <= '0;
      byteCnt_q <= '0;
      acc_q     <= '0;
      wordBuf_q <= '0;
      wen_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      coreRst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lenLo_q   <= lenLo_d;
      lastIdx_q <= lastIdx_d;
      wordCnt_q <= wordCnt_d;
      byteCnt_q <= byteCnt_d;
      acc_q     <= acc_d;
      wordBuf_q <= wordBuf_d;
      wen_q     <= wen_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      coreRst_q <= coreRst_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Restart has priority over any byte; lastIdx holds N-1 so an N = 2^IMEM_AW
  // image ends on the all-ones address and the word counter wraps harmlessly.
  always_comb begin
    state_d   = state_q;
    lenLo_d   = lenLo_q;
    lastIdx_d = lastIdx_q;
    wordCnt_d = wordCnt_q;
    byteCnt_d = byteCnt_q;
    acc_d     = acc_q;
    wordBuf_d = wordBuf_q;
    wen_d     = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    coreRst_d = coreRst_q;
    done_d    = done_q;
    err_d     = err_q;

    if (restart_i) begin
      state_d   = LEN0;
      wordCnt_d = '0;
      byteCnt_d = '0;
      acc_d     = '0;
      wordBuf_d = '0;
      coreRst_d = 1'b1;
      done_d    = 1'b0;
      err_d     = 1'b0;
    end else if (accept) begin
      unique case (state_q)
        LEN0: begin
          lenLo_d = bus.byte_data_i;
          state_d = LEN1;
        end
        LEN1: begin
          if ({1'b0, lenWord} > CAPACITY) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else if (lenWord == 16'd0) begin
            state_d = CSUM;
          end else begin
            state_d   = DATA;
            lastIdx_d = IMEM_AW'(lenWord - 16'd1);
          end
        end
        DATA: begin
          acc_d     = acc_q ^ bus.byte_data_i;
          byteCnt_d = byteCnt_q + 2'd1;
          unique case (byteCnt_q)
            2'd0: wordBuf_d[7:0]   = bus.byte_data_i;
            2'd1: wordBuf_d[15:8]  = bus.byte_data_i;
            2'd2: wordBuf_d[23:16] = bus.byte_data_i;
            default: begin
              wen_d     = 1'b1;
              addr_d    = wordCnt_q;
              wdata_d   = {bus.byte_data_i, wordBuf_q};
              wordCnt_d = wordCnt_q + IMEM_AW'(1);
              if (wordCnt_q == lastIdx_q) state_d = CSUM;
            end
          endcase
        end
        CSUM: begin
          if (bus.byte_data_i == acc_q) begin
            state_d   = DONE;
            done_d    = 1'b1;
            coreRst_d = 1'b0;
          end else begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.byte_ready_o = ready;
  assign bus.imem_wen_o   = wen_q;
  assign bus.imem_addr_o  = addr_q;
  assign bus.imem_wdata_o = wdata_q;
  assign core_rst_o       = coreRst_q;
  assign load_done_o      = done_q;
  assign load_err_o       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: stimulus changes and sampling happen on
// the falling edge, and a monitor logs every write strobe seen there.
module tb_imem_loader;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic reset;
  logic restart_i;
  logic core_rst_o;
  logic load_done_o;
  logic load_err_o;

  int tests = 0;
  int fails = 0;

  int          addrQ[$];
  logic [31:0] dataQ[$];
  logic [31:0] frameWords[16];
  logic [7:0]  csum;
  logic [7:0]  nomFrame[11];

  imem_loader_if #(.IMEM_AW(AW)) bus ();

  imem_loader #(.IMEM_AW(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .restart_i   (restart_i),
    .core_rst_o  (core_rst_o),
    .load_done_o (load_done_o),
    .load_err_o  (load_err_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.imem_wen_o === 1'b1) begin
      addrQ.push_back(int'(bus.imem_addr_o));
      dataQ.push_back(bus.imem_wdata_o);
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkWrite(input string tag, input int idx, input int expAddr, input logic [31:0] expData);
    checkOutput({tag, "_addr"}, (idx < addrQ.size()) ? 32'(addrQ[idx]) : 32'hFFFF_FFFF, 32'(expAddr));
    checkOutput({tag, "_data"}, (idx < dataQ.size()) ? dataQ[idx] : 32'hDEAD_BEEF, expData);
  endtask

  // Called on a falling edge; returns on the falling edge right after the byte is taken.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    int waited;
    bus.byte_valid_i = 1'b0;
    repeat (gap) @(negedge clk);
    bus.byte_valid_i = 1'b1;
    bus.byte_data_i  = b;
    #1;
    waited = 0;
    while (bus.byte_ready_o !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) checkOutput("accept_timeout", 32'(bus.byte_ready_o), 32'd1);
    else @(negedge clk);
    bus.byte_valid_i = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] w, input int maxGap);
    for (int k = 0; k < 4; k++)
      applyStimulus(w[8*k +: 8], (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0);
  endtask

  task automatic pulseRestart();
    restart_i = 1'b1;
    @(negedge clk);
    restart_i = 1'b0;
  endtask

  task automatic clearLog();
    addrQ.delete();
    dataQ.delete();
  endtask

  initial begin
    reset            = 1'b1;
    restart_i        = 1'b0;
    bus.byte_valid_i = 1'b0;
    bus.byte_data_i  = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rst_wen",   32'(bus.imem_wen_o),   32'd0);
    checkOutput("rst_addr",  32'(bus.imem_addr_o),  32'd0);
    checkOutput("rst_wdata", bus.imem_wdata_o,      32'd0);
    checkOutput("rst_core",  32'(core_rst_o),       32'd1);
    checkOutput("rst_done",  32'(load_done_o),      32'd0);
    checkOutput("rst_err",   32'(load_err_o),       32'd0);
    checkOutput("rst_ready", 32'(bus.byte_ready_o), 32'd1);
    @(negedge clk);

    // Nominal N=2 image; XOR of the eight data bytes is 0x90.
    nomFrame = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
    clearLog();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(nomFrame[i], 0);
      if (i == 5) begin
        checkOutput("nom_w0_wen",   32'(bus.imem_wen_o),  32'd1);
        checkOutput("nom_w0_addr",  32'(bus.imem_addr_o), 32'd0);
        checkOutput("nom_w0_wdata", bus.imem_wdata_o,     32'h0000_0013);
      end
      if (i == 6) checkOutput("nom_w0_pulse_end", 32'(bus.imem_wen_o), 32'd0);
      if (i == 9) begin
        checkOutput("nom_w1_wen",   32'(bus.imem_wen_o),  32'd1);
        checkOutput("nom_w1_addr",  32'(bus.imem_addr_o), 32'd1);
        checkOutput("nom_w1_wdata", bus.imem_wdata_o,     32'h0010_0093);
      end
    end
    checkOutput("nom_pre_done", 32'(load_done_o), 32'd0);
    checkOutput("nom_pre_core", 32'(core_rst_o),  32'd1);
    applyStimulus(nomFrame[10], 0);
    checkOutput("nom_done",  32'(load_done_o),      32'd1);
    checkOutput("nom_core",  32'(core_rst_o),       32'd0);
    checkOutput("nom_err",   32'(load_err_o),       32'd0);
    checkOutput("nom_ready", 32'(bus.byte_ready_o), 32'd0);
    checkOutput("nom_count", 32'(addrQ.size()),     32'd2);
    checkWrite("nom_log0", 0, 0, 32'h0000_0013);
    checkWrite("nom_log1", 1, 1, 32'h0010_0093);

    // Same frame with a wrong checksum.
    pulseRestart();
    checkOutput("rs1_core", 32'(core_rst_o),  32'd1);
    checkOutput("rs1_done", 32'(load_done_o), 32'd0);
    clearLog();
    nomFrame[10] = 8'h84;
    for (int i = 0; i < 11; i++) applyStimulus(nomFrame[i], 0);
    checkOutput("bad_err",   32'(load_err_o),       32'd1);
    checkOutput("bad_core",  32'(core_rst_o),       32'd1);
    checkOutput("bad_done",  32'(load_done_o),      32'd0);
    checkOutput("bad_ready", 32'(bus.byte_ready_o), 32'd0);
    checkOutput("bad_count", 32'(addrQ.size()),     32'd2);

    // Empty image.
    pulseRestart();
    checkOutput("rs2_err", 32'(load_err_o), 32'd0);
    clearLog();
    applyStimulus(8'h00, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h00, 0);
    checkOutput("empty_done",  32'(load_done_o),  32'd1);
    checkOutput("empty_core",  32'(core_rst_o),   32'd0);
    checkOutput("empty_count", 32'(addrQ.size()), 32'd0);

    // Oversize N=1025: rejected right after LEN_HI, nothing further accepted.
    pulseRestart();
    clearLog();
    applyStimulus(8'h01, 0);
    applyStimulus(8'h04, 0);
    checkOutput("over_err",   32'(load_err_o),       32'd1);
    checkOutput("over_ready", 32'(bus.byte_ready_o), 32'd0);
    bus.byte_valid_i = 1'b1;
    bus.byte_data_i  = 8'h55;
    repeat (3) @(negedge clk);
    checkOutput("over_hold_ready", 32'(bus.byte_ready_o), 32'd0);
    checkOutput("over_hold_err",   32'(load_err_o),       32'd1);
    bus.byte_valid_i = 1'b0;
    checkOutput("over_count", 32'(addrQ.size()), 32'd0);

    // Full-capacity N=1024 with word i = i; every byte value pairs off, so CSUM is 0.
    pulseRestart();
    clearLog();
    applyStimulus(8'h00, 0);
    applyStimulus(8'h04, 0);
    checkOutput("cap_err",   32'(load_err_o),       32'd0);
    checkOutput("cap_ready", 32'(bus.byte_ready_o), 32'd1);
    for (int i = 0; i < 1024; i++) sendWord(32'(i), 0);
    applyStimulus(8'h00, 0);
    checkOutput("cap_done",  32'(load_done_o),  32'd1);
    checkOutput("cap_count", 32'(addrQ.size()), 32'd1024);
    checkWrite("cap_first", 0, 0, 32'd0);
    checkWrite("cap_mid", 513, 513, 32'd513);
    checkWrite("cap_last", 1023, 1023, 32'd1023);

    // 16-word image loaded once gap-free and once with random source gaps.
    csum = 8'h00;
    for (int i = 0; i < 16; i++) begin
      frameWords[i] = 32'h9E37_79B9 * 32'(i + 1);
      csum = csum ^ frameWords[i][7:0] ^ frameWords[i][15:8] ^ frameWords[i][23:16] ^ frameWords[i][31:24];
    end
    for (int pass = 0; pass < 2; pass++) begin
      pulseRestart();
      clearLog();
      applyStimulus(8'd16, 0);
      applyStimulus(8'h00, 0);
      for (int i = 0; i < 16; i++) sendWord(frameWords[i], (pass == 0) ? 0 : 5);
      applyStimulus(csum, (pass == 0) ? 0 : 3);
      checkOutput(pass == 0 ? "bp0_done" : "bp1_done", 32'(load_done_o), 32'd1);
      checkOutput(pass == 0 ? "bp0_count" : "bp1_count", 32'(addrQ.size()), 32'd16);
      for (int i = 0; i < 16; i++)
        checkWrite(pass == 0 ? "bp0_wr" : "bp1_wr", i, i, frameWords[i]);
    end

    // Restart after 2.5 words of a 4-word frame with a byte offered in the same cycle.
    pulseRestart();
    clearLog();
    applyStimulus(8'h04, 0);
    applyStimulus(8'h00, 0);
    sendWord(frameWords[0], 0);
    sendWord(frameWords[1], 0);
    applyStimulus(frameWords[2][7:0], 0);
    applyStimulus(frameWords[2][15:8], 0);
    bus.byte_valid_i = 1'b1;
    bus.byte_data_i  = 8'hC3;
    restart_i        = 1'b1;
    #1;
    checkOutput("mid_ready_low", 32'(bus.byte_ready_o), 32'd0);
    @(negedge clk);
    restart_i        = 1'b0;
    bus.byte_valid_i = 1'b0;
    checkOutput("mid_core",  32'(core_rst_o),   32'd1);
    checkOutput("mid_done",  32'(load_done_o),  32'd0);
    checkOutput("mid_count", 32'(addrQ.size()), 32'd2);
    clearLog();
    applyStimulus(8'h01, 0);
    applyStimulus(8'h00, 0);
    sendWord(32'hCAFE_F00D, 0);
    applyStimulus(8'hC9, 0);
    checkOutput("mid_new_done",  32'(load_done_o),  32'd1);
    checkOutput("mid_new_count", 32'(addrQ.size()), 32'd1);
    checkWrite("mid_new_wr", 0, 0, 32'hCAFE_F00D);

    // Asynchronous reset in the middle of word 2 of a 3-word frame.
    pulseRestart();
    clearLog();
    applyStimulus(8'h03, 0);
    applyStimulus(8'h00, 0);
    sendWord(32'h1122_3344, 0);
    sendWord(32'h5566_7788, 0);
    applyStimulus(8'hAA, 0);
    checkOutput("ar_pre_addr", 32'(bus.imem_addr_o), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("ar_wen",   32'(bus.imem_wen_o),  32'd0);
    checkOutput("ar_addr",  32'(bus.imem_addr_o), 32'd0);
    checkOutput("ar_wdata", bus.imem_wdata_o,     32'd0);
    checkOutput("ar_core",  32'(core_rst_o),      32'd1);
    checkOutput("ar_done",  32'(load_done_o),     32'd0);
    checkOutput("ar_err",   32'(load_err_o),      32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("ar_ready", 32'(bus.byte_ready_o), 32'd1);
    clearLog();
    applyStimulus(8'h01, 0);
    applyStimulus(8'h00, 0);
    sendWord(32'h0050_0513, 0);
    applyStimulus(8'h46, 0);
    checkOutput("ar_new_done",  32'(load_done_o),  32'd1);
    checkOutput("ar_new_core",  32'(core_rst_o),   32'd0);
    checkOutput("ar_new_count", 32'(addrQ.size()), 32'd1);
    checkWrite("ar_new_wr", 0, 0, 32'h0050_0513);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
